axis_packet_adapter: RTL and testbench

AXIS_PACKET_ADAPTER -- requirements
Module: axis_packet_adapter

---
 rtl/axis_adapter_config.sv | 23 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/axis_packet_adapter.sv | 223 ++++++++++++++++++++++
 tb/tb_axis_packet_adapter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_adapter_config.sv
// Shared configuration for axis_packet_adapter: beat-count helpers, input FSM
// state encoding and the fifo_count width for the default FIFO depth.
package axis_adapter_config;

  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned FIFO_CNT_W         = $clog2(FIFO_DEPTH_DEFAULT) + 1;

  // Number of stream beats needed to carry a word of the given width.
  function automatic int unsigned beat_count(input int unsigned width,
                                             input int unsigned axis_width);
    return (width + axis_width - 1) / axis_width;
  endfunction

  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } in_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count and a look-ahead read of
// the entry behind the head (lets the consumer chain words without a bubble).
module sync_fifo
  import axis_adapter_config::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [WIDTH-1:0]       head_next,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = fifo_cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    rd_next  = rd_ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head      = mem_q[rd_ptr_q];
  assign head_next = mem_q[rd_next];
  assign count     = count_q;

endmodule

// File: rtl/axis_packet_adapter.sv
// AXI-Stream <-> network word adapter: deserializes input beats into words and
// serializes buffered result words back to a stream. Optional framing via
// macro AXIS_PACKET_ADAPTER_TLAST_EN.
module axis_packet_adapter
  import axis_adapter_config::*;
#(
  parameter int unsigned AXIS_WIDTH = 8,
  parameter int unsigned INP_WIDTH  = 24,
  parameter int unsigned OUT_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic                        net_inp_valid,
  output logic [INP_WIDTH-1:0]        net_inp,
  input  logic                        net_inp_ready,
  input  logic                        net_out_valid,
  input  logic [OUT_WIDTH-1:0]        net_out,
  output logic                        net_out_ready,
  output logic                        m_axis_tvalid,
  output logic [AXIS_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_short
);

  localparam int unsigned IN_BEATS  = beat_count(INP_WIDTH, AXIS_WIDTH);
  localparam int unsigned OUT_BEATS = beat_count(OUT_WIDTH, AXIS_WIDTH);
  localparam int unsigned IN_ASM_W  = IN_BEATS * AXIS_WIDTH;
  localparam int unsigned OUT_ASM_W = OUT_BEATS * AXIS_WIDTH;
  localparam int unsigned IN_CNT_W  = $clog2(IN_BEATS + 1);
  localparam int unsigned OUT_CNT_W = $clog2(OUT_BEATS + 1);
  localparam int unsigned CNT_W     = fifo_cnt_width(FIFO_DEPTH);

  logic in_tlast;
`ifdef AXIS_PACKET_ADAPTER_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
  assign in_tlast = s_axis_tlast;
`else
  localparam bit TLAST_EN = 1'b0;
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign in_tlast     = 1'b0;
`endif

  // Input side state
  in_state_e             state_q, state_d;
  logic [IN_CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [IN_ASM_W-1:0]   asm_q, asm_d, asm_shift;
  logic [INP_WIDTH-1:0]  net_inp_q, net_inp_d;
  logic                  net_inp_valid_q, net_inp_valid_d;
  logic                  s_tready_q, s_tready_d;
  logic                  err_short_q, err_short_d;
  logic                  beat_ok;

  // Output side state
  logic [OUT_ASM_W-1:0]  sh_q, sh_d, padded;
  logic [OUT_CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [AXIS_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  net_out_ready_q, net_out_ready_d;
  logic                  fifo_push, fifo_pop, load, out_last_beat;
  logic [OUT_WIDTH-1:0]  fifo_head, fifo_head_next, load_word;
  logic [CNT_W-1:0]      fifo_count_next;

  // Deserializer FSM: shift beats in MSB first, hold the word until taken.
  always_comb begin
    state_d         = state_q;
    in_cnt_d        = in_cnt_q;
    asm_d           = asm_q;
    net_inp_d       = net_inp_q;
    net_inp_valid_d = net_inp_valid_q;
    s_tready_d      = s_tready_q;
    err_short_d     = 1'b0;
    beat_ok         = s_axis_tvalid && s_tready_q;
    asm_shift       = (asm_q << AXIS_WIDTH) | IN_ASM_W'(s_axis_tdata);
    case (state_q)
      COLLECT: begin
        s_tready_d = 1'b1;
        if (beat_ok) begin
          if (in_cnt_q == IN_CNT_W'(IN_BEATS - 1)) begin
            state_d         = PRESENT;
            in_cnt_d        = '0;
            asm_d           = '0;
            net_inp_d       = asm_shift[IN_ASM_W-1 -: INP_WIDTH];
            net_inp_valid_d = 1'b1;
            s_tready_d      = 1'b0;
          end else if (in_tlast) begin
            in_cnt_d    = '0;
            asm_d       = '0;
            err_short_d = 1'b1;
          end else begin
            asm_d    = asm_shift;
            in_cnt_d = in_cnt_q + IN_CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        s_tready_d = 1'b0;
        if (net_inp_ready) begin
          state_d         = COLLECT;
          net_inp_valid_d = 1'b0;
          s_tready_d      = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Serializer: the word being sent stays at the FIFO head until its last
  // beat is accepted, so the following word is read from head_next (or
  // bypassed from net_out when it is being pushed that same cycle).
  always_comb begin
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    sh_d          = sh_q;
    out_cnt_d     = out_cnt_q;
    fifo_pop      = 1'b0;
    load          = 1'b0;
    load_word     = fifo_head;
    padded        = '0;
    fifo_push     = net_out_valid && net_out_ready_q;
    out_last_beat = (out_cnt_q == OUT_CNT_W'(OUT_BEATS - 1));
    if (!m_valid_q) begin
      if (fifo_count != '0) begin
        load      = 1'b1;
        load_word = fifo_head;
      end
    end else if (m_axis_tready) begin
      if (out_last_beat) begin
        fifo_pop = 1'b1;
        if (fifo_count >= CNT_W'(2)) begin
          load      = 1'b1;
          load_word = fifo_head_next;
        end else if (fifo_push) begin
          load      = 1'b1;
          load_word = net_out;
        end else begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end else begin
        m_data_d  = sh_q[OUT_ASM_W-1 -: AXIS_WIDTH];
        sh_d      = sh_q << AXIS_WIDTH;
        out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
        m_last_d  = TLAST_EN && (int'(out_cnt_q) + 2 == int'(OUT_BEATS));
      end
    end
    if (load) begin
      padded    = OUT_ASM_W'(load_word) << (OUT_ASM_W - OUT_WIDTH);
      m_valid_d = 1'b1;
      m_data_d  = padded[OUT_ASM_W-1 -: AXIS_WIDTH];
      sh_d      = padded << AXIS_WIDTH;
      out_cnt_d = '0;
      m_last_d  = TLAST_EN && (OUT_BEATS == 1);
    end
    fifo_count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    net_out_ready_d = (fifo_count_next < CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= COLLECT;
      in_cnt_q        <= '0;
      asm_q           <= '0;
      net_inp_q       <= '0;
      net_inp_valid_q <= 1'b0;
      s_tready_q      <= 1'b0;
      err_short_q     <= 1'b0;
      sh_q            <= '0;
      out_cnt_q       <= '0;
      m_valid_q       <= 1'b0;
      m_data_q        <= '0;
      m_last_q        <= 1'b0;
      net_out_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      in_cnt_q        <= in_cnt_d;
      asm_q           <= asm_d;
      net_inp_q       <= net_inp_d;
      net_inp_valid_q <= net_inp_valid_d;
      s_tready_q      <= s_tready_d;
      err_short_q     <= err_short_d;
      sh_q            <= sh_d;
      out_cnt_q       <= out_cnt_d;
      m_valid_q       <= m_valid_d;
      m_data_q        <= m_data_d;
      m_last_q        <= m_last_d;
      net_out_ready_q <= net_out_ready_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (net_out),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .head_next (fifo_head_next),
    .count     (fifo_count)
  );

  assign s_axis_tready = s_tready_q;
  assign net_inp_valid = net_inp_valid_q;
  assign net_inp       = net_inp_q;
  assign net_out_ready = net_out_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tlast  = m_last_q;
  assign err_short     = err_short_q;

endmodule

// File: tb/tb_axis_packet_adapter.sv
// Directed bench for axis_packet_adapter (8/24/12, depth 4); expectations
// follow AXIS_PACKET_ADAPTER_TLAST_EN when it is defined.
module tb_axis_packet_adapter;

`ifdef AXIS_PACKET_ADAPTER_TLAST_EN
  localparam bit TLAST_EN = 1'b1;
`else
  localparam bit TLAST_EN = 1'b0;
`endif
  localparam int GUARD = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        net_inp_valid, net_inp_ready;
  logic [23:0] net_inp;
  logic        net_out_valid, net_out_ready;
  logic [11:0] net_out;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic [2:0]  fifo_count;
  logic        err_short;

  axis_packet_adapter #(
    .AXIS_WIDTH (8),
    .INP_WIDTH  (24),
    .OUT_WIDTH  (12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .net_inp_valid (net_inp_valid),
    .net_inp       (net_inp),
    .net_inp_ready (net_inp_ready),
    .net_out_valid (net_out_valid),
    .net_out       (net_out),
    .net_out_ready (net_out_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .fifo_count    (fifo_count),
    .err_short     (err_short)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp;
  } in_vec_t;

  typedef struct {
    logic [11:0] word;
    logic [7:0]  exp0, exp1;
  } out_vec_t;

  in_vec_t  in_tab  [4];
  out_vec_t out_tab [4];
  logic [7:0] burst_exp [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, GUARD);
  endtask

  // All tasks start and end on a falling edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int g = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    while (!s_axis_tready && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) timeout("send_beat");
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic take_word(input string name, input logic [23:0] exp);
    check({name, "_valid"}, 32'(net_inp_valid), 32'h1);
    check({name, "_data"}, 32'(net_inp), 32'(exp));
    net_inp_ready = 1'b1;
    @(negedge clk);
    net_inp_ready = 1'b0;
    check({name, "_released"}, 32'(net_inp_valid), 32'h0);
  endtask

  task automatic push_word(input logic [11:0] w);
    int g = 0;
    net_out_valid = 1'b1;
    net_out       = w;
    while (!net_out_ready && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) timeout("push_word");
    @(negedge clk);
    net_out_valid = 1'b0;
  endtask

  task automatic get_beat(output logic [7:0] d, output logic l);
    int g = 0;
    while (!m_axis_tvalid && g < GUARD) begin
      @(negedge clk);
      g++;
    end
    if (g >= GUARD) timeout("get_beat");
    d = m_axis_tdata;
    l = m_axis_tlast;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] d;
    logic       l;

    in_tab[0] = '{8'h00, 8'h00, 8'h00, 24'h000000};
    in_tab[1] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    in_tab[2] = '{8'h12, 8'h34, 8'h56, 24'h123456};
    in_tab[3] = '{8'h80, 8'h01, 8'h7F, 24'h80017F};
    out_tab[0] = '{12'hABC, 8'hAB, 8'hC0};
    out_tab[1] = '{12'h000, 8'h00, 8'h00};
    out_tab[2] = '{12'hFFF, 8'hFF, 8'hF0};
    out_tab[3] = '{12'h5A5, 8'h5A, 8'h50};
    burst_exp = '{8'h12, 8'h30, 8'h45, 8'h60, 8'h78, 8'h90, 8'hDE, 8'hF0};

    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    net_inp_ready = 1'b0;
    net_out_valid = 1'b0;
    net_out       = '0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_s_tready", 32'(s_axis_tready), 32'h0);
    check("rst_net_out_ready", 32'(net_out_ready), 32'h0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_fifo_count", 32'(fifo_count), 32'h0);
    check("rst_net_inp", 32'(net_inp), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_tready", 32'(s_axis_tready), 32'h1);
    check("post_rst_net_out_ready", 32'(net_out_ready), 32'h1);

    // Word held under backpressure.
    send_beat(8'hA1, 1'b0);
    send_beat(8'hB2, 1'b0);
    send_beat(8'hC3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(net_inp_valid), 32'h1);
      check("stall_data", 32'(net_inp), 32'hA1B2C3);
      check("stall_s_tready", 32'(s_axis_tready), 32'h0);
      @(negedge clk);
    end
    take_word("stall_word", 24'hA1B2C3);
    check("after_hs_s_tready", 32'(s_axis_tready), 32'h1);

    for (int i = 0; i < 4; i++) begin
      send_beat(in_tab[i].b0, 1'b0);
      send_beat(in_tab[i].b1, 1'b0);
      send_beat(in_tab[i].b2, 1'b0);
      take_word("in_tab", in_tab[i].exp);
    end

    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_word(out_tab[i].word);
      get_beat(d, l);
      check("out_beat0", 32'(d), 32'(out_tab[i].exp0));
      check("out_last0", 32'(l), 32'h0);
      get_beat(d, l);
      check("out_beat1", 32'(d), 32'(out_tab[i].exp1));
      check("out_last1", 32'(l), 32'(TLAST_EN));
    end

    // Fill the FIFO while the stream is stalled, then drain without gaps.
    m_axis_tready = 1'b0;
    push_word(12'h123);
    push_word(12'h456);
    push_word(12'h789);
    push_word(12'hDEF);
    check("full_count", 32'(fifo_count), 32'h4);
    check("full_net_out_ready", 32'(net_out_ready), 32'h0);
    repeat (2) @(negedge clk);
    check("hold_valid", 32'(m_axis_tvalid), 32'h1);
    check("hold_data", 32'(m_axis_tdata), 32'h12);
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("burst_valid", 32'(m_axis_tvalid), 32'h1);
      check("burst_data", 32'(m_axis_tdata), 32'(burst_exp[i]));
      check("burst_last", 32'(m_axis_tlast), 32'(TLAST_EN && (i % 2 == 1)));
      @(negedge clk);
    end
    check("drained_valid", 32'(m_axis_tvalid), 32'h0);
    check("drained_count", 32'(fifo_count), 32'h0);
    check("drained_net_out_ready", 32'(net_out_ready), 32'h1);

    // Short frame: tlast on the second of three beats.
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
`ifdef AXIS_PACKET_ADAPTER_TLAST_EN
    check("short_err_pulse", 32'(err_short), 32'h1);
    check("short_no_word", 32'(net_inp_valid), 32'h0);
    @(negedge clk);
    check("short_err_clear", 32'(err_short), 32'h0);
    send_beat(8'h01, 1'b0);
    send_beat(8'h02, 1'b0);
    send_beat(8'h03, 1'b0);
    take_word("after_short", 24'h010203);
`else
    check("short_err_tied", 32'(err_short), 32'h0);
    send_beat(8'hCC, 1'b0);
    check("tlast_ignored_err", 32'(err_short), 32'h0);
    take_word("tlast_ignored", 24'hAABBCC);
`endif

    // Reset mid-word and with a buffered output word.
    m_axis_tready = 1'b0;
    push_word(12'h777);
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_tready", 32'(s_axis_tready), 32'h0);
    check("midrst_net_out_ready", 32'(net_out_ready), 32'h0);
    check("midrst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("midrst_m_tdata", 32'(m_axis_tdata), 32'h0);
    check("midrst_m_tlast", 32'(m_axis_tlast), 32'h0);
    check("midrst_fifo_count", 32'(fifo_count), 32'h0);
    check("midrst_net_inp_valid", 32'(net_inp_valid), 32'h0);
    check("midrst_net_inp", 32'(net_inp), 32'h0);
    check("midrst_err", 32'(err_short), 32'h0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("midrst_after_s_tready", 32'(s_axis_tready), 32'h1);
    check("midrst_after_net_out_ready", 32'(net_out_ready), 32'h1);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    take_word("after_rst", 24'h112233);
    check("discarded_out_word", 32'(m_axis_tvalid), 32'h0);
    check("discarded_count", 32'(fifo_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
